// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and a
// synchronous-read instruction memory (slave). Read data is valid
// exactly one cycle after the cycle in which imem_en is high.
interface instr_fetch_unit_if #(
   parameter int ADDR_W = 9
);
   logic              imem_en;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_rdata;

   modport master (
      output imem_en,
      output imem_addr,
      input  imem_rdata
   );

   modport slave (
      input  imem_en,
      input  imem_addr,
      output imem_rdata
   );
endinterface : instr_fetch_unit_if

// File: rtl/instr_fetch_unit.sv
// Fetch stage feeding instruction decode. Issues word addresses to a
// synchronous-read instruction memory, returns instructions through a
// registered IF/ID output, absorbs one in-flight return in a skid
// buffer when decode stalls, and stops fetching once HALT is fetched.
module instr_fetch_unit #(
   parameter int          ADDR_W  = 9,
   parameter logic [3:0]  HALT_OP = 4'hF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   input  logic [ADDR_W-1:0]   start_pc,
   input  logic                stall,
   instr_fetch_unit_if.master  imem,
   output logic [31:0]         instr_out,
   output logic                instr_valid,
   output logic [ADDR_W-1:0]   pc_out,
   output logic                busy,
   output logic                done
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_HALTED
   } state_t;

   state_t            state_q;
   state_t            state_d;

   logic [ADDR_W-1:0] pc_q;
   logic              req_valid_q;
   logic [ADDR_W-1:0] req_pc_q;
   logic [31:0]       skid_q;
   logic [ADDR_W-1:0] skid_pc_q;
   logic              skid_valid_q;
   logic              halt_seen_q;

   logic              accept;
   logic              ret_halt;
   logic              issue;
   logic              out_load;
   logic              start_ok;

   // Handshake and issue decisions shared by the FSM and the datapath.
   // A returning HALT blocks issue in the same cycle, so no address
   // beyond HALT is ever requested.
   assign accept   = instr_valid & ~stall;
   assign ret_halt = req_valid_q & (imem.imem_rdata[31:28] == HALT_OP);
   assign issue    = (state_q == S_RUN) & ~stall & ~skid_valid_q & ~halt_seen_q & ~ret_halt;
   assign out_load = accept | ~instr_valid;
   assign start_ok = start & (state_q != S_RUN);

   assign imem.imem_en   = issue;
   assign imem.imem_addr = pc_q;
   assign busy           = (state_q == S_RUN);
   assign done           = (state_q == S_HALTED);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: start launches from IDLE/HALTED, accepted HALT ends RUN.
   always_comb begin
      // NOTE: assigning the default first means every path drives state_d, so no latch is inferred.
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start) state_d = S_RUN;
         S_RUN:    if (accept && (instr_out[31:28] == HALT_OP)) state_d = S_HALTED;
         S_HALTED: if (start) state_d = S_RUN;
         default:  state_d = S_IDLE;
      endcase
   end

   // PC, outstanding-request tracking and HALT-fetched flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q        <= '0;
         req_valid_q <= 1'b0;
         req_pc_q    <= '0;
         halt_seen_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments here so every register samples pre-edge values.
         if (start_ok) begin
            pc_q <= start_pc;
         end else if (issue) begin
            pc_q <= pc_q + 1'b1;
         end
         req_valid_q <= issue;
         if (issue) begin
            req_pc_q <= pc_q;
         end
         if (ret_halt) begin
            halt_seen_q <= 1'b1;
         end
         if (start_ok) begin
            halt_seen_q <= 1'b0;
         end
      end
   end

   // IF/ID output register and skid buffer: skid drains first, then the
   // memory return; a return that cannot reach the output lands in skid.
   always_ff @(posedge clk) begin
      if (rst) begin
         instr_out    <= '0;
         pc_out       <= '0;
         instr_valid  <= 1'b0;
         skid_q       <= '0;
         skid_pc_q    <= '0;
         skid_valid_q <= 1'b0;
      end else if (out_load) begin
         if (skid_valid_q) begin
            instr_out    <= skid_q;
            pc_out       <= skid_pc_q;
            instr_valid  <= 1'b1;
            skid_valid_q <= req_valid_q;
            if (req_valid_q) begin
               skid_q    <= imem.imem_rdata;
               skid_pc_q <= req_pc_q;
            end
         end else if (req_valid_q) begin
            instr_out   <= imem.imem_rdata;
            pc_out      <= req_pc_q;
            instr_valid <= 1'b1;
         end else begin
            instr_valid <= 1'b0;
         end
      end else if (req_valid_q) begin
         skid_q       <= imem.imem_rdata;
         skid_pc_q    <= req_pc_q;
         skid_valid_q <= 1'b1;
      end
   end

endmodule : instr_fetch_unit
